seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multi-digit seven-segment driver for the Tetris score and level displays. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. The result is latched atomically into a display register, and the DIGITS anodes are time-multiplexed with segment decoding, leading-zero blanking and overflow saturation. It replaces the single-digit combinational decoder used until now.

Parameters:
DIGITS, 4, number of display digits (1..8); digit 0 = least significant.
BIN_W, 14, width of the binary input value.
REFRESH_DIV, 100000, clock cycles each digit stays enabled (>=2).
SEG_ACTIVE_LOW, 1, 1 = seg and an outputs are active-low; 0 = active-high.
BLANK_LEADING, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
value  in  BIN_W  binary value to display; sampled only on an accepted load.
load  in  1  one-cycle strobe requesting conversion of value.
busy  out  1  high while a conversion is in progress.
done  out  1  one-cycle pulse when the display register updates.
an  out  DIGITS  digit enables, one-hot (polarity per SEG_ACTIVE_LOW).
seg  out  7  segments; seg[0]=a ... seg[6]=g (polarity per SEG_ACTIVE_LOW).

Behaviour:
- Reset (synchronous, active-high): display register = all zero BCD (shows "0"); busy=0; done=0; refresh counter=0; digit index=0; an = all digits off; seg = all segments off. Reset wins over a simultaneous load.
- Convert FSM, states IDLE and SHIFT.
  - IDLE: load=1 accepts the request; latch value into the shift register, counter=BIN_W, go to SHIFT; busy=1 from the next cycle.
  - Saturation at accept: if value >= 10^DIGITS, latch 10^DIGITS-1 instead, so the display shows all 9s.
  - SHIFT: one double-dabble step per cycle. Add 3 to every BCD nibble >=5, then shift left one bit, binary MSB entering bit 0 of the BCD field.
  - Exit SHIFT after BIN_W steps. In that same edge, copy the BCD field to the display register, pulse done for one cycle, clear busy, return to IDLE.
  - Latency: a load accepted at edge t gives done=1 and the new display in cycle t+BIN_W+1. busy is high for exactly BIN_W cycles.
  - load while busy=1 is ignored, not queued.
  - The display register changes only at done; it never shows a partial conversion.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments modulo DIGITS (DIGITS-1 wraps to 0).
  - Scanning runs continuously and is independent of conversion state.
  - an and seg are registered from the digit index and display register, so outputs lag the index by 1 cycle.
  - First enabled digit after reset is digit 0, in cycle 1 after reset deasserts.
  - Each digit is enabled for exactly REFRESH_DIV consecutive cycles.
- Decode, active-high gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Nibbles >9 cannot occur; decode them as blank. When SEG_ACTIVE_LOW=1, invert both seg and an.
- Blanking (BLANK_LEADING=1): digit k>0 is blank (all segments off, anode still scanned) when it and every higher digit are zero.
- Ties and width: BIN_W may exceed the bits needed for 10^DIGITS-1; saturation compare is done at BIN_W width. BCD field is 4*DIGITS bits; overflow beyond it cannot occur after saturation.

Test Plan:
Default parameters apply except REFRESH_DIV=4.
1. Reset -> an=1111, seg=1111111, busy=0, done=0. Release reset, then load 0 -> digit 0 shows "0" (seg=1000000); digits 1-3 blank (seg=1111111). Each anode low for exactly 4 cycles, in order 1110, 1101, 1011, 0111, 1110.
2. load=1 with value=1234 at edge t -> busy=1 for cycles t+1..t+14; done=1 only in cycle t+15. Then an=1110 gives seg=0011001 ("4"); an=1101 "3" (0110000); an=1011 "2" (0100100); an=0111 "1" (1111001).
3. load value=7 -> digit 0 seg=1111000; digits 1-3 seg=1111111. load value=1005 -> digits show 1,0,0,5 with no blanking of the inner zeros.
4. load value=12000 -> saturates to 9999; every digit seg=0010000; done pulses once.
5. load 1234, then load 5678 three cycles later (busy=1) -> second load ignored; display 1234; single done pulse.
6. Assert rst mid-conversion (cycle t+5) -> next cycle busy=0, no done, display shows "0". A subsequent load of 42 converts normally in 14 busy cycles.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus between a score/level source and the seven-segment scan driver:
// load request with value, conversion status, and the multiplexed display pins.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic [BIN_W-1:0]  value;
  logic              load;
  logic              busy;
  logic              done;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  modport master (
    output value, load,
    input  busy, done, an, seg
  );

  modport slave (
    input  value, load,
    output busy, done, an, seg
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment driver: sequential binary-to-BCD conversion into an
// atomically updated display register, then time-multiplexed digit scanning.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int BIN_W          = 14,
  parameter int REFRESH_DIV    = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_driver_if.slave  bus
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int          RCNT_W  = $clog2(REFRESH_DIV);
  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] POW10   = pow10(DIGITS);
  localparam logic [6:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{SEG_ACTIVE_LOW != 0}};

  // Values that do not fit in DIGITS decimal places are clamped to all nines.
  function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
    if (64'(v) >= POW10) return BIN_W'(POW10 - 64'd1);
    return v;
  endfunction

  function automatic logic [BCD_W+BIN_W-1:0] dabble_step(
    input logic [BCD_W-1:0] bcd,
    input logic [BIN_W-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  function automatic logic [6:0] decode7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               done_q, done_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic               accept;
  logic               step;
  logic               last_step;
  logic               busy;
  logic [3:0]         nib;
  logic               hi_zero;
  logic [6:0]         seg_pat;
  logic [DIGITS-1:0]  an_pat;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:  accept = bus.load;
      SHIFT: begin
        busy      = 1'b1;
        step      = 1'b1;
        last_step = (cnt_q == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Conversion datapath: the display register is only written on the final step.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    done_d = 1'b0;
    if (accept) begin
      bin_d = saturate(bus.value);
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (step) begin
      {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
      cnt_d          = cnt_q - CNT_W'(1);
      if (last_step) begin
        disp_d = bcd_d;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is leading-blank when it and every more significant digit are zero.
  always_comb begin
    nib     = disp_q[4*int'(idx_q) +: 4];
    hi_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_q) && disp_q[4*k +: 4] != 4'd0) hi_zero = 1'b0;
    end
    seg_pat = decode7(nib);
    if (BLANK_LEADING != 0 && idx_q != '0 && hi_zero) seg_pat = 7'd0;
    an_pat = DIGITS'(1) << idx_q;
    seg_d  = (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
    an_d   = (SEG_ACTIVE_LOW != 0) ? ~an_pat : an_pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      disp_q <= '0;
      done_q <= 1'b0;
      rcnt_q <= '0;
      idx_q  <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      done_q <= done_d;
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 4-cycle refresh: vector table plus
// hand-built sequences for busy overlap and mid-conversion reset.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = 14;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  typedef struct packed {
    logic [BIN_W-1:0] value;
    logic [3:0][6:0]  segs;
  } vec_t;

  typedef struct packed {
    int              due;
    logic [3:0][6:0] segs;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  sb_t  sb[$];
  logic [3:0][6:0] exp_disp = {BL, BL, BL, S0};
  vec_t vecs [10];

  seg7_scan_driver_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  seg7_scan_driver #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard consumer: every done must match a queued load at the right cycle.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_t item;
        item = sb.pop_front();
        chk("done_cycle", cyc, item.due);
        exp_disp = item.segs;
      end
    end
  end

  task automatic check_display(input string tag);
    logic [3:0][6:0] got;
    int bad_an;
    got    = 'x;
    bad_an = 0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: got[0] = bus.seg;
        4'b1101: got[1] = bus.seg;
        4'b1011: got[2] = bus.seg;
        4'b0111: got[3] = bus.seg;
        default: bad_an++;
      endcase
    end
    for (int k = 0; k < DIGITS; k++)
      chk($sformatf("%s_digit%0d", tag, k), got[k], exp_disp[k]);
    chk({tag, "_an_onehot"}, bad_an, 0);
  endtask

  task automatic run_vec(input logic [BIN_W-1:0] v, input logic [3:0][6:0] segs, input string tag);
    int nbusy;
    @(negedge clk);
    bus.value = v;
    bus.load  = 1'b1;
    sb.push_back('{due: cyc + 1 + LAT, segs: segs});
    @(negedge clk);
    bus.load = 1'b0;
    nbusy    = int'(bus.busy);
    repeat (19) begin
      @(negedge clk);
      nbusy += int'(bus.busy);
    end
    chk({tag, "_busy_cycles"}, nbusy, LAT);
    chk({tag, "_drained"}, sb.size(), 0);
    sb.delete();
    check_display(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    int d;

    vecs[0] = '{value: 14'd0,     segs: {BL, BL, BL, S0}};
    vecs[1] = '{value: 14'd1234,  segs: {S1, S2, S3, S4}};
    vecs[2] = '{value: 14'd7,     segs: {BL, BL, BL, S7}};
    vecs[3] = '{value: 14'd1005,  segs: {S1, S0, S0, S5}};
    vecs[4] = '{value: 14'd12000, segs: {S9, S9, S9, S9}};
    vecs[5] = '{value: 14'd9999,  segs: {S9, S9, S9, S9}};
    vecs[6] = '{value: 14'd10000, segs: {S9, S9, S9, S9}};
    vecs[7] = '{value: 14'd16383, segs: {S9, S9, S9, S9}};
    vecs[8] = '{value: 14'd10,    segs: {BL, BL, S1, S0}};
    vecs[9] = '{value: 14'd860,   segs: {BL, S8, S6, S0}};

    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    // Scan order and dwell straight out of reset, display holding "0".
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      d  = ((k - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      es = (d == 0) ? S0 : BL;
      chk($sformatf("scan_an_c%0d", k), bus.an, ea);
      chk($sformatf("scan_seg_c%0d", k), bus.seg, es);
    end

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].value, vecs[i].segs, $sformatf("vec%0d", i));

    // Second load while busy must be dropped.
    @(negedge clk);
    bus.value = 14'd1234;
    bus.load  = 1'b1;
    sb.push_back('{due: cyc + 1 + LAT, segs: {S1, S2, S3, S4}});
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    bus.value = 14'd5678;
    bus.load  = 1'b1;
    @(negedge clk);
    chk("overlap_busy_at_2nd_load", bus.busy, 1'b1);
    bus.load = 1'b0;
    repeat (30) @(negedge clk);
    chk("overlap_drained", sb.size(), 0);
    sb.delete();
    check_display("overlap");

    // Reset in the middle of a conversion aborts it without a done pulse.
    @(negedge clk);
    bus.value = 14'd1234;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_an", bus.an, 4'hF);
    chk("midrst_seg", bus.seg, 7'h7F);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    exp_disp = {BL, BL, BL, S0};
    check_display("midrst");
    run_vec(14'd42, {BL, BL, S4, S2}, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
